// File: rtl/rv32ima_pkg.sv
// Shared types and defaults for the rv32ima memory subsystem.
// Holds the arbiter FSM states, grant encoding and default timeout depth.
package rv32ima_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
  typedef enum logic {GNT_I, GNT_D} arb_grant_t;

  localparam int ARB_MAX_WAIT_DEF = 16;

  function automatic arb_grant_t arb_other(input arb_grant_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant between instruction fetch and data requests.
// A tie goes to whichever requester was not granted last.
module rr_arbiter2
  import rv32ima_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  arb_grant_t last_grant,
  output logic       gnt_valid,
  output arb_grant_t gnt
);

  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) begin
      gnt = arb_other(last_grant);
    end else if (req_d) begin
      gnt = GNT_D;
    end else begin
      gnt = GNT_I;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single RAM port between the I-fetch and D-memory requesters.
// One access at a time: latch at grant, hold until ram_ready or timeout, ack for one cycle.
module mem_bus_arbiter
  import rv32ima_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = ARB_MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_strb,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              err,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic [3:0]        ram_strb,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam bit TIMEOUT_EN = (MAX_WAIT != 0);

  arb_state_t       state_q, state_d;
  arb_grant_t       last_q, last_d;
  arb_grant_t       owner_q, owner_d;
  logic             op_wen_q, op_wen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              ram_ren_d, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_store_d;
  logic [3:0]        ram_strb_d;
  logic [DATA_W-1:0] i_rdata_d, d_rdata_d;
  logic              i_ready_d, d_ready_d, err_d;

  logic       d_req, gnt_valid, timeout;
  arb_grant_t gnt;

  assign d_req   = d_ren | d_wen;
  assign timeout = TIMEOUT_EN && (cnt_q == TIMEOUT_AT);

  rr_arbiter2 u_rr (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    op_wen_d    = op_wen_q;
    cnt_d       = cnt_q;
    ram_ren_d   = 1'b0;
    ram_wen_d   = 1'b0;
    ram_addr_d  = ram_addr;
    ram_store_d = ram_store;
    ram_strb_d  = ram_strb;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (gnt_valid) begin
          state_d = ARB_BUSY;
          last_d  = gnt;
          owner_d = gnt;
          cnt_d   = '0;
          if (gnt == GNT_D) begin
            op_wen_d    = d_wen;
            ram_addr_d  = d_addr;
            ram_store_d = d_wdata;
            ram_strb_d  = d_strb;
          end else begin
            op_wen_d   = 1'b0;
            ram_addr_d = i_addr;
            ram_strb_d = 4'hF;
          end
          ram_ren_d = ~op_wen_d;
          ram_wen_d = op_wen_d;
        end
      end
      ARB_BUSY: begin
        if (ram_ready || timeout) begin
          state_d = ARB_DONE;
          err_d   = ~ram_ready;
          // A timed-out access returns zero; a completed write leaves rdata alone.
          if (owner_q == GNT_I) begin
            i_ready_d = 1'b1;
            i_rdata_d = ram_ready ? ram_load : '0;
          end else begin
            d_ready_d = 1'b1;
            if (!ram_ready) begin
              d_rdata_d = '0;
            end else if (!op_wen_q) begin
              d_rdata_d = ram_load;
            end
          end
        end else begin
          ram_ren_d = ~op_wen_q;
          ram_wen_d = op_wen_q;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ARB_IDLE;
      last_q    <= GNT_I;
      owner_q   <= GNT_I;
      op_wen_q  <= 1'b0;
      cnt_q     <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      ram_strb  <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      op_wen_q  <= op_wen_d;
      cnt_q     <= cnt_d;
      ram_ren   <= ram_ren_d;
      ram_wen   <= ram_wen_d;
      ram_addr  <= ram_addr_d;
      ram_store <= ram_store_d;
      ram_strb  <= ram_strb_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
      i_ready   <= i_ready_d;
      d_ready   <= d_ready_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run scored against a transaction-level model.
module tb_mem_bus_arbiter;
  import rv32ima_pkg::*;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_req, d_ren, d_wen, ram_ready;
  logic [31:0] i_addr, d_addr, d_wdata, ram_load;
  logic [3:0]  d_strb;
  logic [31:0] i_rdata, d_rdata, ram_addr, ram_store;
  logic        i_ready, d_ready, err, ram_ren, ram_wen;
  logic [3:0]  ram_strb;
  logic        any_out;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
    .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_strb(ram_strb), .ram_load(ram_load), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  assign any_out = |{i_rdata, i_ready, d_rdata, d_ready, err, ram_ren, ram_wen,
                     ram_addr, ram_store, ram_strb};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RAM responder: each access takes a queued latency (BUSY cycles before ram_ready).
  bit          ram_in_acc = 0;
  int          ram_cnt, ram_cur_lat;
  logic [31:0] ram_cur_load;
  int          ram_lat_q[$];
  logic [31:0] ram_load_q[$];

  task automatic ram_respond();
    if (ram_ren || ram_wen) begin
      if (!ram_in_acc) begin
        ram_in_acc   = 1;
        ram_cnt      = 0;
        ram_cur_lat  = (ram_lat_q.size() != 0) ? ram_lat_q.pop_front() : 0;
        ram_cur_load = (ram_load_q.size() != 0) ? ram_load_q.pop_front() : $urandom;
      end else begin
        ram_cnt++;
      end
      ram_ready = (ram_cnt == ram_cur_lat);
      ram_load  = ram_ready ? ram_cur_load : $urandom;
    end else begin
      ram_in_acc = 0;
      ram_ready  = 1'($urandom_range(0, 1));
      ram_load   = $urandom;
    end
  endtask

  task automatic clear_inputs();
    i_req = 0; d_ren = 0; d_wen = 0; ram_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_strb = 0; ram_load = 0;
    ram_in_acc = 0;
    ram_lat_q.delete();
    ram_load_q.delete();
  endtask

  task automatic apply_reset();
    nrst = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset outputs", any_out, 0);
    nrst = 1;
  endtask

  typedef struct {
    logic        is_d, ren, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int          lat;
    logic [31:0] load;
    logic        exp_wen;
    logic [3:0]  exp_strb;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic is_d, ren, wen, input logic [31:0] addr, wdata,
                              input logic [3:0] strb, input int lat, input logic [31:0] load,
                              input logic exp_wen, input logic [3:0] exp_strb,
                              input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
    vec_t v;
    v.is_d = is_d; v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.lat = lat; v.load = load; v.exp_wen = exp_wen; v.exp_strb = exp_strb;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    return v;
  endfunction

  // One isolated access from IDLE; exp_lat counts cycles from request to ready pulse.
  task automatic run_vec(input vec_t v, input string tag);
    int en_cycles = 0;
    bit seen = 0;
    ram_lat_q.push_back(v.lat);
    ram_load_q.push_back(v.load);
    @(negedge clk);
    if (v.is_d) begin
      d_ren = v.ren; d_wen = v.wen; d_addr = v.addr; d_wdata = v.wdata; d_strb = v.strb;
    end else begin
      i_req = 1; i_addr = v.addr;
    end
    ram_respond();
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_strb = 4'($urandom);
      if (ram_ren || ram_wen) begin
        if (en_cycles == 0) begin
          check({tag, " bus"}, {ram_ren, ram_wen, ram_strb, ram_addr},
                {!v.exp_wen, v.exp_wen, v.exp_strb, v.addr});
          if (v.is_d) check({tag, " store"}, ram_store, v.wdata);
        end
        en_cycles++;
      end
      if (i_ready || d_ready) begin
        seen = 1;
        check({tag, " ack"}, {i_ready, d_ready, err}, {!v.is_d, v.is_d, v.exp_err});
        check({tag, " latency"}, k, v.exp_lat);
        check({tag, " busy cycles"}, en_cycles, v.exp_lat - 1);
        check({tag, " rdata"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        i_req = 0; d_ren = 0; d_wen = 0;
      end
      ram_respond();
    end
    check({tag, " ready seen"}, seen, 1);
  endtask

  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic        ren, wen;
    int          gap;
  } txn_t;

  // Transaction-level model: grant by the round-robin rule, completion time from RAM latency.
  task automatic run_random(input int n);
    txn_t        iq[$], dq[$], t, cur;
    int          ii = 0, di = 0, i_avail, d_avail, free_at = 0, g = 0, r = 0, c = 0, lat;
    bit          cur_v = 0, cur_to = 0, pi, pd, en_x, rdy_x;
    arb_grant_t  cur_own = GNT_I, m_last = GNT_I;
    logic [31:0] cur_load = 0, exp_ir = 0, exp_dr = 0;
    int          op;
    for (int i = 0; i < n; i++) begin
      t.addr = $urandom; t.wdata = $urandom; t.strb = 4'($urandom_range(0, 15));
      t.gap = $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      t.ren = (op != 1); t.wen = (op != 0);
      dq.push_back(t);
      t.addr = $urandom; t.ren = 1; t.wen = 0; t.gap = $urandom_range(0, 3);
      iq.push_back(t);
    end
    i_avail = iq[0].gap;
    d_avail = dq[0].gap;
    cur = iq[0];
    while ((ii < n || di < n || cur_v) && c < 4000) begin
      @(negedge clk);
      en_x  = cur_v && c > g && c < r;
      rdy_x = cur_v && c == r;
      if (rdy_x) begin
        if (cur_own == GNT_I) exp_ir = cur_to ? 32'h0 : cur_load;
        else if (cur_to) exp_dr = 32'h0;
        else if (!cur.wen) exp_dr = cur_load;
      end
      check("rnd ctl", {ram_ren, ram_wen, i_ready, d_ready, err},
            {en_x && !cur.wen, en_x && cur.wen, rdy_x && cur_own == GNT_I,
             rdy_x && cur_own == GNT_D, rdy_x && cur_to});
      if (en_x) check("rnd bus", {ram_strb, ram_addr},
                      {(cur_own == GNT_I) ? 4'hF : cur.strb, cur.addr});
      if (en_x && cur_own == GNT_D) check("rnd store", ram_store, cur.wdata);
      check("rnd rdata", {i_rdata, d_rdata}, {exp_ir, exp_dr});
      if (rdy_x) cur_v = 0;

      pi = ii < n && c >= i_avail;
      pd = di < n && c >= d_avail;
      i_req   = pi;
      i_addr  = pi ? iq[ii].addr : $urandom;
      d_ren   = pd && dq[di].ren;
      d_wen   = pd && dq[di].wen;
      d_addr  = pd ? dq[di].addr : $urandom;
      d_wdata = pd ? dq[di].wdata : $urandom;
      d_strb  = pd ? dq[di].strb : 4'($urandom);
      if (cur_v && c < r) begin
        if (cur_own == GNT_I) begin
          i_req = 1'($urandom_range(0, 1));
        end else begin
          d_ren = 1'($urandom_range(0, 1));
          d_wen = 1'($urandom_range(0, 1));
        end
      end

      if (!cur_v && c >= free_at && (pi || pd)) begin
        if (pi && pd) cur_own = (m_last == GNT_I) ? GNT_D : GNT_I;
        else          cur_own = pd ? GNT_D : GNT_I;
        m_last = cur_own;
        if (cur_own == GNT_D) begin cur = dq[di]; di++; end
        else begin cur = iq[ii]; ii++; end
        lat      = $urandom_range(0, MW + 1);
        cur_load = $urandom;
        ram_lat_q.push_back(lat);
        ram_load_q.push_back(cur_load);
        cur_to  = lat >= MW;
        g       = c;
        r       = cur_to ? c + MW + 1 : c + lat + 2;
        free_at = r + 1;
        cur_v   = 1;
        if (cur_own == GNT_D) d_avail = (di < n) ? r + dq[di].gap : 0;
        else                  i_avail = (ii < n) ? r + iq[ii].gap : 0;
      end
      ram_respond();
      c++;
    end
    check("rnd completed", {ii == n, di == n, !cur_v}, 3'b111);
  endtask

  vec_t vecs[8];

  initial begin
    int order, starts, acks, bad;
    bit prev_en;

    vecs[0] = mk(0, 1, 0, 32'h100, 32'h0, 4'h0, 2, 32'hDEADBEEF, 0, 4'hF, 0, 32'hDEADBEEF, 4);
    vecs[1] = mk(1, 1, 0, 32'h040, 32'h55, 4'hC, 0, 32'hCAFEF00D, 0, 4'hC, 0, 32'hCAFEF00D, 2);
    vecs[2] = mk(1, 0, 1, 32'h204, 32'h12345678, 4'h3, 1, 32'hBAD0BAD0, 1, 4'h3, 0, 32'hCAFEF00D, 3);
    vecs[3] = mk(1, 1, 1, 32'h208, 32'hA5A5A5A5, 4'h8, 0, 32'h11111111, 1, 4'h8, 0, 32'hCAFEF00D, 2);
    vecs[4] = mk(0, 1, 0, 32'h10C, 32'h0, 4'h0, MW - 1, 32'h0BADCAFE, 0, 4'hF, 0, 32'h0BADCAFE, 5);
    vecs[5] = mk(1, 1, 0, 32'h300, 32'h0, 4'hF, 99, 32'h22222222, 0, 4'hF, 1, 32'h0, MW + 1);
    vecs[6] = mk(0, 1, 0, 32'h110, 32'h0, 4'h0, MW, 32'h33333333, 0, 4'hF, 1, 32'h0, MW + 1);
    vecs[7] = mk(0, 1, 0, 32'h114, 32'h0, 4'h0, 0, 32'h13579BDF, 0, 4'hF, 0, 32'h13579BDF, 2);

    nrst = 0;
    clear_inputs();
    #3;
    check("outputs at time zero", any_out, 0);
    apply_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Tie right after reset: D first, then strict alternation while both keep requesting.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      ram_lat_q.push_back(0);
      ram_load_q.push_back(32'hA0 + i);
    end
    @(negedge clk);
    i_req = 1; d_ren = 1; i_addr = 32'h300; d_addr = 32'h400;
    ram_respond();
    order = 0;
    for (int k = 1; k <= 20 && order < 4; k++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        check("tie owner", {i_ready, d_ready}, (order % 2 == 0) ? 2'b01 : 2'b10);
        check("tie cycle", k, 2 + 3 * order);
        check("tie rdata", d_ready ? d_rdata : i_rdata, 32'hA0 + order);
        order++;
        if (order == 4) begin i_req = 0; d_ren = 0; end
      end
      ram_respond();
    end
    check("tie acks", order, 4);

    // Request held through DONE must not start a second access.
    ram_lat_q.push_back(0);
    ram_load_q.push_back(32'h5A5A5A5A);
    @(negedge clk);
    i_req = 1; i_addr = 32'h500;
    ram_respond();
    starts = 0; acks = 0; prev_en = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((ram_ren || ram_wen) && !prev_en) starts++;
      prev_en = ram_ren || ram_wen;
      if (i_ready) acks++;
      if (k == 3) i_req = 0;
      ram_respond();
    end
    check("holdover accesses", starts, 1);
    check("holdover acks", acks, 1);

    // Reset in the middle of BUSY aborts silently.
    ram_lat_q.push_back(99);
    @(negedge clk);
    d_ren = 1; d_addr = 32'h600;
    ram_respond();
    repeat (2) begin @(negedge clk); ram_respond(); end
    check("busy before reset", ram_ren, 1);
    #2 nrst = 0;
    #1 check("reset mid-busy outputs", any_out, 0);
    clear_inputs();
    @(negedge clk);
    nrst = 1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (i_ready || d_ready || err || ram_ren || ram_wen) bad++;
      ram_respond();
    end
    check("no pulse after reset", bad, 0);
    run_vec(mk(0, 1, 0, 32'h180, 32'h0, 4'h0, 1, 32'h44444444, 0, 4'hF, 0, 32'h44444444, 3),
            "post-reset");

    apply_reset();
    run_random(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
